// File: rtl/lut_layer_pkg.sv
// -----------------------------------------------------------------------------
// lut_layer_pkg
// Shared types and helpers for the LUT layer pipeline.
//   fsm_e       : table-controller state (CLEAR after reset, then RUN)
//   clog2_min1  : ceil(log2(n)) but never below 1, used for index widths
//   even_parity : parity bit that makes the total number of ones even
// Optional feature macro used by the users of this package:
//   LUT_LAYER_PARITY_EN
// -----------------------------------------------------------------------------
package lut_layer_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } fsm_e;

   // A single neuron still needs a one-bit select, hence the floor of 1.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Callers zero-extend their entry to 8 bits; zeros do not change parity.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/lut_layer_pipe_if.sv
// -----------------------------------------------------------------------------
// lut_layer_pipe_if
// Bundles the streaming input, streaming output and table-config signals of
// lut_layer_pipe.
//   s_valid/s_ready/s_data          : input samples, neuron k address at
//                                     s_data[k*IN_BITS +: IN_BITS]
//   m_valid/m_ready/m_data          : results, neuron k output at
//                                     m_data[k*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_ready/cfg_neuron/
//   cfg_addr/cfg_data               : table write port
// Modports: master = the environment around the layer, slave = the layer.
// -----------------------------------------------------------------------------
interface lut_layer_pipe_if #(
   parameter int N_NEURONS = 4,
   parameter int IN_BITS   = 4,
   parameter int OUT_BITS  = 2
);
   import lut_layer_pkg::*;

   localparam int NW = clog2_min1(N_NEURONS);

   logic                            s_valid;
   logic                            s_ready;
   logic [N_NEURONS*IN_BITS-1:0]    s_data;
   logic                            m_valid;
   logic                            m_ready;
   logic [N_NEURONS*OUT_BITS-1:0]   m_data;
   logic                            cfg_we;
   logic                            cfg_ready;
   logic [NW-1:0]                   cfg_neuron;
   logic [IN_BITS-1:0]              cfg_addr;
   logic [OUT_BITS-1:0]             cfg_data;

   modport master (
      output s_valid, s_data, m_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
      input  s_ready, m_valid, m_data, cfg_ready
   );

   modport slave (
      input  s_valid, s_data, m_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
      output s_ready, m_valid, m_data, cfg_ready
   );

endinterface

// File: rtl/lut_neuron_ram.sv
// -----------------------------------------------------------------------------
// lut_neuron_ram
// Truth table of one neuron: DEPTH x W distributed RAM with one synchronous
// write port and one asynchronous read port.
//   clk    : write clock
//   we     : write strobe
//   waddr  : write entry
//   wdata  : write word
//   raddr  : read entry
//   rdata  : read word (combinational from raddr)
// The array has no reset; the owner clears it by writing every entry.
// -----------------------------------------------------------------------------
module lut_neuron_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // A read in the same cycle as a write to that entry sees the old word,
   // because the array only changes at the clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_layer_pipe.sv
// -----------------------------------------------------------------------------
// lut_layer_pipe
// N_NEURONS LogicNets neurons evaluated in parallel, each a runtime-writable
// truth table mapping IN_BITS to OUT_BITS, in a two-stage valid/ready pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lut_layer_pipe_if.slave (stream in, stream out, config)
//   parity_err : sticky table parity error (only with LUT_LAYER_PARITY_EN)
// After reset the controller spends 2**IN_BITS cycles zeroing every table
// (CLEAR), then accepts samples and config writes (RUN) until the next reset.
// Optional feature macro: LUT_LAYER_PARITY_EN adds a parity bit per entry,
// checked on every read.
// -----------------------------------------------------------------------------
module lut_layer_pipe
   import lut_layer_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IN_BITS   = 4,
   parameter int OUT_BITS  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   lut_layer_pipe_if.slave  bus
`ifdef LUT_LAYER_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int DEPTH = 2 ** IN_BITS;
   localparam int NW    = clog2_min1(N_NEURONS);
`ifdef LUT_LAYER_PARITY_EN
   localparam int RW    = OUT_BITS + 1;
`else
   localparam int RW    = OUT_BITS;
`endif

   fsm_e                          state_q, state_d;
   logic [IN_BITS-1:0]            clr_cnt_q, clr_cnt_d;
   logic                          s1_valid_q, s1_valid_d;
   logic [N_NEURONS*IN_BITS-1:0]  s1_data_q, s1_data_d;
   logic                          m_valid_q, m_valid_d;
   logic [N_NEURONS*OUT_BITS-1:0] m_data_q, m_data_d;

   logic                          run;
   logic                          s2_adv;
   logic                          s1_adv;
   logic                          s_ready_int;
   logic                          cfg_hit;
   logic [IN_BITS-1:0]            wr_addr;
   logic [RW-1:0]                 wr_word;
   logic [N_NEURONS-1:0]          ram_we;
   logic [RW-1:0]                 rd_word [N_NEURONS];
   logic [N_NEURONS*OUT_BITS-1:0] lut_out;
`ifdef LUT_LAYER_PARITY_EN
   logic                          parity_err_q, parity_err_d;
   logic                          par_bad;
`endif

   assign run = (state_q == RUN);

   // Handshake rules: S2 moves when its result is taken or it is empty; S1
   // moves when S2 moves or S1 is empty. s_ready depends only on state and
   // downstream readiness, never on s_valid.
   assign s2_adv      = !m_valid_q || bus.m_ready;
   assign s1_adv      = s2_adv || !s1_valid_q;
   assign s_ready_int = run && s1_adv;

   // Controller next state: CLEAR walks the entry index once through the
   // whole table depth, one entry per cycle, then hands over to RUN.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == IN_BITS'(DEPTH - 1)) begin
            state_d = RUN;
         end
      end
   end

   // Shared write port. During CLEAR every table is written with zero at the
   // clear index; during RUN only the addressed neuron takes the config word,
   // and an out-of-range neuron select writes nothing.
   always_comb begin
      wr_addr = clr_cnt_q;
      wr_word = '0;
      cfg_hit = 1'b0;
      if (run) begin
         wr_addr = bus.cfg_addr;
`ifdef LUT_LAYER_PARITY_EN
         wr_word = {even_parity(8'(bus.cfg_data)), bus.cfg_data};
`else
         wr_word = bus.cfg_data;
`endif
         cfg_hit = bus.cfg_we && (32'(bus.cfg_neuron) < N_NEURONS);
      end
   end

   for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
      assign ram_we[k] = !run || (cfg_hit && (32'(bus.cfg_neuron) == k));

      lut_neuron_ram #(
         .DEPTH (DEPTH),
         .AW    (IN_BITS),
         .W     (RW)
      ) u_ram (
         .clk   (clk),
         .we    (ram_we[k]),
         .waddr (wr_addr),
         .wdata (wr_word),
         .raddr (s1_data_q[k*IN_BITS +: IN_BITS]),
         .rdata (rd_word[k])
      );
   end

   // Gather the per-neuron table outputs into the result word, and flag any
   // entry whose stored parity disagrees with its data.
   always_comb begin
      lut_out = '0;
`ifdef LUT_LAYER_PARITY_EN
      par_bad = 1'b0;
`endif
      for (int k = 0; k < N_NEURONS; k++) begin
         lut_out[k*OUT_BITS +: OUT_BITS] = rd_word[k][OUT_BITS-1:0];
`ifdef LUT_LAYER_PARITY_EN
         if (even_parity(8'(rd_word[k][OUT_BITS-1:0])) != rd_word[k][OUT_BITS]) begin
            par_bad = 1'b1;
         end
`endif
      end
   end

   // Pipeline next state. S1 captures the sample addresses on a handshake;
   // S2 captures the table outputs read at the S1 addresses. A stalled S2
   // keeps m_valid and m_data exactly as they are.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      if (s1_adv) begin
         s1_valid_d = bus.s_valid && s_ready_int;
         if (bus.s_valid && s_ready_int) begin
            s1_data_d = bus.s_data;
         end
      end
      if (s2_adv) begin
         m_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            m_data_d = lut_out;
         end
      end
   end

`ifdef LUT_LAYER_PARITY_EN
   // The error flag rises with the result that carried the bad entry and
   // stays set until reset.
   always_comb begin
      parity_err_d = parity_err_q | (s2_adv && s1_valid_q && par_bad);
   end
`endif

   // All control and pipeline state. Reset drops in-flight samples and
   // restarts the clear sweep from entry 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CLEAR;
         clr_cnt_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
`ifdef LUT_LAYER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
`ifdef LUT_LAYER_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.s_ready   = s_ready_int;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = m_data_q;
   assign bus.cfg_ready = run;
`ifdef LUT_LAYER_PARITY_EN
   assign parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_lut_layer_pipe.sv
// -----------------------------------------------------------------------------
// tb_lut_layer_pipe
// Self-checking bench for lut_layer_pipe (3 neurons, 4-bit addresses, 2-bit
// results). Stimulus pushes expected results into a queue; a monitor pops and
// compares whenever a result is transferred. With LUT_LAYER_PARITY_EN defined
// a stored bit is corrupted and parity_err is observed.
// -----------------------------------------------------------------------------
module tb_lut_layer_pipe;
   import lut_layer_pkg::*;

   localparam int N     = 3;
   localparam int IB    = 4;
   localparam int OB    = 2;
   localparam int DEPTH = 16;
   localparam int NW    = 2;

   typedef logic [N*IB-1:0] in_t;
   typedef logic [N*OB-1:0] out_t;
   typedef struct {
      out_t data;
      int   issued;
      bit   lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
`ifdef LUT_LAYER_PARITY_EN
   logic parity_err;
`endif

   lut_layer_pipe_if #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) bus ();

   lut_layer_pipe #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus)
`ifdef LUT_LAYER_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   run_phase = 0;
   logic [OB-1:0] model [N][DEPTH];
   exp_t expq [$];

   // Free-running clock and a cycle counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bound on total run time in case the design never becomes ready.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counted, and reported only when it disagrees.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference: each neuron looks its own address up in its own table.
   function automatic out_t refOut(input in_t sd);
      out_t r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         r[k*OB +: OB] = model[k][sd[k*IB +: IB]];
      end
      return r;
   endfunction

   function automatic in_t randIn();
      in_t v;
      for (int k = 0; k < N; k++) begin
         v[k*IB +: IB] = IB'($urandom_range(0, DEPTH - 1));
      end
      return v;
   endfunction

   function automatic in_t sameAddr(input int a);
      in_t v;
      for (int k = 0; k < N; k++) begin
         v[k*IB +: IB] = IB'(a);
      end
      return v;
   endfunction

   function automatic void clearModel();
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < DEPTH; a++) begin
            model[k][a] = '0;
         end
      end
   endfunction

   // One cycle of stimulus, driven after the falling edge. A config write
   // affects samples accepted in the same cycle or later (the earlier ones
   // have already been read), so the model is updated before the lookup.
   task automatic applyStimulus(input bit sv, input in_t sd, input bit mr,
                                input bit we, input int wn, input int wa, input int wd,
                                input bit lat, output bit acc);
      exp_t e;
      @(negedge clk);
      bus.s_valid    = sv;
      bus.s_data     = sd;
      bus.m_ready    = mr;
      bus.cfg_we     = we;
      bus.cfg_neuron = NW'(wn);
      bus.cfg_addr   = IB'(wa);
      bus.cfg_data   = OB'(wd);
      #1;
      if (we && run_phase && wn < N) begin
         model[wn][wa] = OB'(wd);
      end
      acc = sv && bus.s_ready;
      if (acc) begin
         e.data   = refOut(sd);
         e.issued = cyc;
         e.lat    = lat;
         expq.push_back(e);
      end
   endtask

   task automatic idle(input bit mr);
      bit acc;
      applyStimulus(0, '0, mr, 0, 0, 0, 0, 0, acc);
   endtask

   task automatic writeEntry(input int n, input int a, input int d);
      bit acc;
      applyStimulus(0, '0, 1, 1, n, a, d, 0, acc);
   endtask

   task automatic sendUntilAccepted(input in_t sd, input bit lat);
      bit acc;
      acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
         applyStimulus(1, sd, 1, 0, 0, 0, 0, lat, acc);
      end
      if (!acc) checkOutput("send_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && expq.size() != 0; i++) idle(1);
      idle(1);
      checkOutput("drain_empty", expq.size(), 0);
   endtask

   // Counts the cycles s_ready stays low after reset release; writes issued
   // meanwhile must be ignored by the design.
   task automatic waitClear(input int limit);
      int cnt;
      cnt = 0;
      bus.cfg_we = 1; bus.cfg_neuron = 0; bus.cfg_addr = 4'd7; bus.cfg_data = 2'd3;
      for (int i = 0; i < limit; i++) begin
         #1;
         if (bus.s_ready) begin
            bus.cfg_we = 0;
            break;
         end
         cnt++;
         @(negedge clk);
      end
      bus.cfg_we = 0;
      checkOutput("clear_len", cnt, DEPTH);
      checkOutput("cfg_ready_run", bus.cfg_ready, 1);
      run_phase = 1;
   endtask

   // Monitor: compares every transferred result with the scoreboard head and
   // checks that a stalled result stays put.
   initial begin
      bit   held;
      out_t held_data;
      exp_t e;
      held = 0;
      held_data = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 0;
         end else begin
            if (held) begin
               checkOutput("hold_valid", bus.m_valid, 1);
               checkOutput("hold_data", bus.m_data, held_data);
            end
            if (bus.m_valid && bus.m_ready) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_output got=%0h want=none", bus.m_data);
               end else begin
                  e = expq.pop_front();
                  checkOutput("result", bus.m_data, e.data);
                  if (e.lat) checkOutput("latency", cyc - e.issued, 2);
               end
            end
            held = bus.m_valid && !bus.m_ready;
            held_data = bus.m_data;
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      bit   acc;
      int   idx;
      in_t  smp [3];

      bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 1;
      bus.cfg_we = 0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
      clearModel();

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_m_valid", bus.m_valid, 0);
      checkOutput("rst_m_data", bus.m_data, 0);
      checkOutput("rst_s_ready", bus.s_ready, 0);
      checkOutput("rst_cfg_ready", bus.cfg_ready, 0);
      @(negedge clk);
      rst_n = 1;
      waitClear(40);

      // Freshly cleared tables read zero, including the entry written in CLEAR
      applyStimulus(1, sameAddr(7), 1, 0, 0, 0, 0, 0, acc);
      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom_range(0, 1), randIn(), 1, 0, 0, 0, 0, 0, acc);
      end
      drain();

      // Neuron 0: 0100->01, 0110->01; stream all addresses back to back
      writeEntry(0, 4, 1);
      writeEntry(0, 6, 1);
      idle(1);
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1, sameAddr(a), 1, 0, 0, 0, 0, 1, acc);
         if (!acc) checkOutput("stream_accept", 0, 1);
      end
      drain();

      // Stall: m_ready low for 5 cycles while offering 3 samples
      for (int i = 0; i < 3; i++) smp[i] = randIn();
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(idx < 3, smp[idx < 3 ? idx : 0], 0, 0, 0, 0, 0, 0, acc);
         if (acc) idx++;
      end
      checkOutput("stall_accepted", idx, 2);
      checkOutput("stall_s_ready", bus.s_ready, 0);
      for (int c = 0; c < 20 && idx < 3; c++) begin
         applyStimulus(1, smp[idx], 1, 0, 0, 0, 0, 0, acc);
         if (acc) idx++;
      end
      checkOutput("stall_all_sent", idx, 3);
      drain();

      // Collision: second address-3 sample handshakes while the first is read
      // and neuron 0 entry 3 is rewritten; the first sees 00, the second 11.
      applyStimulus(1, sameAddr(3), 1, 0, 0, 0, 0, 1, acc);
      applyStimulus(1, sameAddr(3), 1, 1, 0, 3, 3, 1, acc);
      applyStimulus(1, sameAddr(3), 1, 1, N, 5, 3, 1, acc);
      applyStimulus(1, sameAddr(5), 1, 0, 0, 0, 0, 1, acc);
      drain();

      // Random tables, random valid and ready
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < DEPTH; a++) writeEntry(k, a, $urandom_range(0, 3));
      end
      for (int i = 0; i < 150; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), randIn(), ($urandom_range(0, 9) < 7),
                       0, 0, 0, 0, 0, acc);
      end
      drain();

      // Mid-stream reset with two samples in flight
      applyStimulus(1, randIn(), 1, 0, 0, 0, 0, 0, acc);
      applyStimulus(1, randIn(), 1, 0, 0, 0, 0, 0, acc);
      @(negedge clk);
      bus.s_valid = 0;
      rst_n = 0;
      #1;
      checkOutput("midrst_m_valid", bus.m_valid, 0);
      checkOutput("midrst_s_ready", bus.s_ready, 0);
      expq.delete();
      clearModel();
      run_phase = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      waitClear(40);
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1, sameAddr(a), 1, 0, 0, 0, 0, 1, acc);
      end
      drain();

`ifdef LUT_LAYER_PARITY_EN
      // Corrupt neuron 1 entry 5 (stored 01 with parity 1) to data 00
      checkOutput("parity_clean", parity_err, 0);
      writeEntry(1, 5, 1);
      idle(1);
      force dut.g_neuron[1].u_ram.mem_q[5] = 3'b100;
      @(negedge clk);
      release dut.g_neuron[1].u_ram.mem_q[5];
      model[1][5] = 2'b00;
      applyStimulus(1, sameAddr(5), 1, 0, 0, 0, 0, 0, acc);
      idle(1);
      checkOutput("parity_before", parity_err, 0);
      idle(1);
      checkOutput("parity_rise", parity_err, 1);
      repeat (5) idle(1);
      checkOutput("parity_sticky", parity_err, 1);
      drain();
`endif

      checkOutput("final_queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lut_layer_pipe.md
Name: lut_layer_pipe

Overview:
- Parametrised, pipelined successor to the fixed combinational per-neuron truth-table ROMs.
- Evaluates N_NEURONS LogicNets neurons in parallel. Each neuron maps IN_BITS of quantised input to OUT_BITS through its own runtime-writable truth table.
- Tables are cleared after reset by an internal FSM and are then programmable through a config port.
- Sits between quantised layers, with valid/ready streaming on both sides.

Parameters:
- N_NEURONS, 4, number of neurons (min 1)
- IN_BITS, 4, per-neuron input (address) width; table depth 2**IN_BITS (1..8)
- OUT_BITS, 2, per-neuron output width (1..8)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  N_NEURONS*IN_BITS  neuron k address at [k*IN_BITS +: IN_BITS]
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  N_NEURONS*OUT_BITS  neuron k result at [k*OUT_BITS +: OUT_BITS]
- cfg_we  in  1  table write strobe
- cfg_ready  out  1  config writes accepted this cycle
- cfg_neuron  in  max(1,$clog2(N_NEURONS))  target neuron
- cfg_addr  in  IN_BITS  table entry
- cfg_data  in  OUT_BITS  entry value

Behaviour:
- Reset values: m_valid=0, m_data=0, s_ready=0, cfg_ready=0, FSM=CLEAR, clear counter=0, both pipeline stages invalid.
- Reset asserted mid-operation: all in-flight samples are dropped, FSM returns to CLEAR, and clearing restarts from entry 0.
- FSM state CLEAR:
  - One entry index per cycle, written to 0 in all neurons in parallel.
  - Lasts exactly 2**IN_BITS cycles, then moves to RUN.
  - s_ready=0 and cfg_ready=0 throughout.
- FSM state RUN: persists until reset. cfg_ready=1.
- Config writes:
  - cfg_we && cfg_ready writes cfg_data into table[cfg_neuron][cfg_addr].
  - cfg_we in CLEAR is ignored.
  - cfg_neuron >= N_NEURONS is ignored; no table is modified.
- Pipeline stage 1 (S1): registers s_data on a handshake (s_valid && s_ready).
- Pipeline stage 2 (S2): reads all tables at the S1 address and registers the result into m_data.
- Latency: 2 cycles from input handshake to m_valid, assuming no stall.
- Throughput: 1 sample/cycle.
- Stall and ready rules:
  - S2 advances when !m_valid || m_ready.
  - S1 advances when S2 advances or S1 is empty.
  - s_ready = RUN && (S1 empty || S2 advances).
  - No combinational path from s_valid to s_ready.
- Output stability: while m_valid && !m_ready, m_data and m_valid hold stable.
- Read/write collision: a table read and a config write to the same entry in the same cycle return the old value (read-before-write). Later samples see the new value.
- Config writes in RUN are legal while samples are in flight and do not stall the data path.
- Table storage: distributed RAM, asynchronous read, read address taken from the S1 register.

Optional Feature:
- Macro: LUT_LAYER_PARITY_EN.
- When defined:
  - Each entry stores an even-parity bit, computed on write; CLEAR writes parity 0.
  - S2 checks parity per neuron on every read.
  - Any mismatch sets output port parity_err (1 bit, reset 0). The flag is sticky until rst_n.
  - m_data is still delivered unchanged.
- When undefined: no parity storage and no parity_err port.

Decomposition:
- Package lut_layer_pkg:
  - fsm enum {CLEAR, RUN}
  - function clog2_min1
  - parity function
  - localparams DEPTH=2**IN_BITS and NW=max(1,$clog2(N_NEURONS)) are computed locally in the module.
- Sub-module lut_neuron_ram, one instance per neuron via generate:
  - DEPTH x (OUT_BITS[+1]) storage
  - one synchronous write port, one asynchronous read port

Test Plan:
- Reset then idle: s_ready=0 for exactly 16 cycles (IN_BITS=4), then 1. Samples sent before tables are written return m_data=0.
- Program neuron 0 with entry 0100->01 and 0110->01, all others 00, at N_NEURONS=1. Stream the 16 addresses back-to-back with m_ready=1: outputs appear at 2-cycle latency, 1/cycle, and match the 4-in/2-out reference table.
- Stall: hold m_ready=0 for 5 cycles with 3 samples sent. Required: s_ready drops after 2 samples, m_data stays stable, and no sample is lost or duplicated after release.
- Collision: the sample at address 3 in S1 coincides with a write of cfg_data=2'b11 to address 3. The result is the old 00 and the next sample at address 3 returns 11. A write with cfg_neuron=N_NEURONS is ignored.
- Mid-stream reset: assert rst_n=0 with 2 samples in flight. Required: m_valid=0 immediately, CLEAR reruns, and previously programmed entries read back 0.
- With LUT_LAYER_PARITY_EN, force a stored bit flip in neuron 1: parity_err rises on the cycle that entry's result is presented and stays 1 until reset.
